// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the multi-cycle DIV/DIVU unit that sits beside EX.
//   - DIV_DATA_W : default operand width
//   - IDLE / BY_ZERO / ON / END : divider FSM state encodings
//   - EXE_DIV_OP / EXE_DIVU_OP : EX aluop codes that select the divider
//   - is_div_aluop() : true when an aluop routes through the divider
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_DATA_W = 32;

    // Divider FSM state encodings
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] BY_ZERO = 2'b01;
    localparam logic [1:0] ON      = 2'b10;
    localparam logic [1:0] END     = 2'b11;

    // EX aluop codes served by the divider
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    function automatic logic is_div_aluop(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem          : partial remainder (always < divisor on entry)
//   divisor      : divisor magnitude
//   dividend_bit : next dividend bit shifted into the partial remainder
//   rem_next     : partial remainder after this iteration
//   q_bit        : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] divisor,
    input  logic              dividend_bit,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W-1:0] low_s;
    logic [DATA_W:0]   sub_s;

    // Trial subtract of the divisor from {rem, dividend_bit}, restore on borrow.
    // The shifted-out top bit of rem means the partial value is >= 2^DATA_W and
    // therefore always exceeds the divisor; the true difference is then < divisor,
    // so the low DATA_W bits of the wrapped subtract are exact.
    always_comb begin
        low_s = {rem[DATA_W-2:0], dividend_bit};
        sub_s = {1'b0, low_s} - {1'b0, divisor};
        q_bit = rem[DATA_W-1] | ~sub_s[DATA_W];
        if (q_bit) begin
            rem_next = sub_s[DATA_W-1:0];
        end else begin
            rem_next = low_s;
        end
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU (unsigned).
// EX holds div_start until div_ready, then takes {remainder, quotient}.
//   clk         : pipeline clock
//   reset       : synchronous active-high reset
//   div_start   : request, held by EX until div_ready
//   div_signed  : 1 = DIV, 0 = DIVU (sampled with start)
//   div_opdata1 : dividend (sampled with start)
//   div_opdata2 : divisor  (sampled with start)
//   div_annul   : cancel current operation; wins over start
//   div_result  : {remainder (HI), quotient (LO)}, zero unless div_ready
//   div_ready   : result valid
// Build option: define DIV_EARLY_EXIT_EN to finish in two cycles whenever
// |dividend| < |divisor| (quotient 0, remainder = dividend).
// -----------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                div_start,
    input  logic                div_signed,
    input  logic [DATA_W-1:0]   div_opdata1,
    input  logic [DATA_W-1:0]   div_opdata2,
    input  logic                div_annul,
    output logic [2*DATA_W-1:0] div_result,
    output logic                div_ready
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W-1);
    localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};

    logic [1:0]          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   dividend_r;
    logic [DATA_W-1:0]   divisor_r;
    logic [DATA_W-1:0]   rem_r;
    logic [DATA_W-1:0]   quot_r;
    logic                neg_quot_r;
    logic                neg_rem_r;
    logic                ready_r;
    logic [2*DATA_W-1:0] result_r;

    logic [DATA_W-1:0]   abs1_s;
    logic [DATA_W-1:0]   abs2_s;
    logic [DATA_W-1:0]   rem_next_s;
    logic                q_bit_s;
    logic [DATA_W-1:0]   quot_next_s;
    logic                last_step_s;
    logic                out_valid_s;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                    input logic              is_signed);
        if (is_signed && value[DATA_W-1]) begin
            return ZERO_W - value;
        end else begin
            return value;
        end
    endfunction

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem          (rem_r),
        .divisor      (divisor_r),
        .dividend_bit (dividend_r[DATA_W-1]),
        .rem_next     (rem_next_s),
        .q_bit        (q_bit_s)
    );

    // Operand magnitudes, next quotient and output-valid decode.
    always_comb begin
        abs1_s      = magnitude(div_opdata1, div_signed);
        abs2_s      = magnitude(div_opdata2, div_signed);
        quot_next_s = {quot_r[DATA_W-2:0], q_bit_s};
        last_step_s = (cnt_r == CNT_LAST);
        out_valid_s = (state_r == END) && div_start && !div_annul;
    end

    // Divider FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            dividend_r <= ZERO_W;
            divisor_r  <= ZERO_W;
            rem_r      <= ZERO_W;
            quot_r     <= ZERO_W;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (div_start && !div_annul) begin
                        neg_quot_r <= div_signed & (div_opdata1[DATA_W-1] ^ div_opdata2[DATA_W-1]);
                        neg_rem_r  <= div_signed & div_opdata1[DATA_W-1];
                        dividend_r <= abs1_s;
                        divisor_r  <= abs2_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        rem_r      <= ZERO_W;
                        quot_r     <= ZERO_W;
                        // BY_ZERO is the one-cycle short path: it just carries
                        // the preloaded rem_r/quot_r through to END.
                        if (div_opdata2 == ZERO_W) begin
                            state_r <= BY_ZERO;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (abs1_s < abs2_s) begin
                            state_r <= BY_ZERO;
                            rem_r   <= div_opdata1;
`endif
                        end else begin
                            state_r <= ON;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BY_ZERO: begin
                    if (div_annul) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= END;
                    end
                end
                ON: begin
                    if (div_annul) begin
                        state_r <= IDLE;
                    end else begin
                        dividend_r <= {dividend_r[DATA_W-2:0], 1'b0};
                        cnt_r      <= cnt_r + CNT_ONE;
                        if (last_step_s) begin
                            // Apply signs once the magnitudes are final.
                            quot_r  <= neg_quot_r ? (ZERO_W - quot_next_s) : quot_next_s;
                            rem_r   <= neg_rem_r  ? (ZERO_W - rem_next_s)  : rem_next_s;
                            state_r <= END;
                        end else begin
                            quot_r  <= quot_next_s;
                            rem_r   <= rem_next_s;
                            state_r <= ON;
                        end
                    end
                end
                END: begin
                    if (div_annul || !div_start) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= END;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered handshake outputs: non-zero only while EX is waiting in END.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r  <= 1'b0;
            result_r <= {(2*DATA_W){1'b0}};
        end else if (out_valid_s) begin
            ready_r  <= 1'b1;
            result_r <= {rem_r, quot_r};
        end else begin
            ready_r  <= 1'b0;
            result_r <= {(2*DATA_W){1'b0}};
        end
    end

    assign div_ready  = ready_r;
    assign div_result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed vector table, hand-written
// annul/reset/handshake sequences and random operands against an arithmetic
// reference model. Honours DIV_EARLY_EXIT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[12];

    div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_opdata1 (div_opdata1),
        .div_opdata2 (div_opdata2),
        .div_annul   (div_annul),
        .div_result  (div_result),
        .div_ready   (div_ready)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division (C semantics for DIV), zero for /0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb;
        if (b == 32'd0) return 2;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_EXIT_EN
        if (sa < sb) return 2;
`endif
        return 33;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for div_ready; lat = edges after the start-sampling edge, 0 on timeout.
    task automatic wait_ready(output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (div_ready) begin
                lat = c;
                break;
            end
        end
    endtask

    // Full handshake: start, scramble operands after capture, check latency,
    // result, hold while start is high, and drop one edge after start falls.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        div_opdata1 = a;
        div_opdata2 = b;
        div_signed  = sgn;
        div_start   = 1'b1;
        tick();
        div_opdata1 = $urandom;
        div_opdata2 = $urandom;
        div_signed  = ~sgn;
        wait_ready(lat);
        check({name, " latency"}, 65'(lat), 65'(exp_lat));
        if (lat != 0) begin
            check({name, " result"}, {1'b1, div_result}, {1'b1, exp_res});
            tick();
            tick();
            check({name, " hold"}, {div_ready, div_result}, {1'b1, exp_res});
            div_start = 1'b0;
            tick();
            check({name, " release"}, {div_ready, div_result}, 65'd0);
        end else begin
            div_start = 1'b0;
            tick();
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int ready_seen;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'h0000000E, 32'h00000002};
        vecs[1]  = '{32'hFFFFFFF9,   32'h00000002,   1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{32'hFFFFFFF9,   32'h00000002,   1'b0, 32'h7FFFFFFC, 32'h00000001};
        vecs[3]  = '{32'h00001234,   32'h00000000,   1'b0, 32'h00000000, 32'h00000000};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'h00000000};
        vecs[5]  = '{32'd5,          32'd9,          1'b0, 32'h00000000, 32'h00000005};
        vecs[6]  = '{32'd9,          32'd3,          1'b0, 32'h00000003, 32'h00000000};
        vecs[7]  = '{32'hFFFFFFFF,   32'h00000001,   1'b0, 32'hFFFFFFFF, 32'h00000000};
        vecs[8]  = '{32'h00000007,   32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'h00000001};
        vecs[9]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'h00000003, 32'hFFFFFFFF};
        vecs[10] = '{32'h00000000,   32'h00000005,   1'b1, 32'h00000000, 32'h00000000};
        vecs[11] = '{32'hFFFFFFFB,   32'h00000000,   1'b1, 32'h00000000, 32'h00000000};

        reset       = 1'b1;
        div_start   = 1'b0;
        div_signed  = 1'b0;
        div_opdata1 = 32'd0;
        div_opdata2 = 32'd0;
        div_annul   = 1'b0;
        repeat (3) tick();
        check("reset state", {div_ready, div_result}, 65'd0);
        reset = 1'b0;
        tick();
        check("idle after reset", {div_ready, div_result}, 65'd0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                   {vecs[i].r, vecs[i].q}, ref_lat(vecs[i].a, vecs[i].b, vecs[i].sgn));
        end

        // Annul during iteration 10, then an immediate new start
        div_opdata1 = 32'd1000;
        div_opdata2 = 32'd7;
        div_signed  = 1'b0;
        div_start   = 1'b1;
        tick();
        repeat (10) tick();
        div_annul = 1'b1;
        div_start = 1'b0;
        tick();
        check("annul in ON", {div_ready, div_result}, 65'd0);
        div_annul = 1'b0;
        run_op("after annul 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

        // Annul while the result is being presented
        div_opdata1 = 32'd20;
        div_opdata2 = 32'd3;
        div_start   = 1'b1;
        tick();
        wait_ready(lat);
        check("pre-annul END latency", 65'(lat), 65'd33);
        div_annul = 1'b1;
        tick();
        check("annul in END", {div_ready, div_result}, 65'd0);
        div_annul = 1'b0;
        div_start = 1'b0;
        tick();

        // Annul on the divide-by-zero path
        div_opdata2 = 32'd0;
        div_start   = 1'b1;
        tick();
        div_annul = 1'b1;
        tick();
        div_annul = 1'b0;
        div_start = 1'b0;
        ready_seen = 0;
        repeat (4) begin
            tick();
            if (div_ready) ready_seen++;
        end
        check("annul in BY_ZERO", 65'(ready_seen), 65'd0);

        // Reset mid-ON, then a clean operation leaves no residue
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        div_start   = 1'b1;
        tick();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("reset mid-ON", {div_ready, div_result}, 65'd0);
        div_start = 1'b0;
        tick();
        reset = 1'b0;
        run_op("after reset 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

        // Reset mid-END
        div_opdata1 = 32'd50;
        div_opdata2 = 32'd6;
        div_start   = 1'b1;
        tick();
        wait_ready(lat);
        check("pre-reset END latency", 65'(lat), 65'd33);
        reset = 1'b1;
        tick();
        check("reset mid-END", {div_ready, div_result}, 65'd0);
        div_start = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Start and annul together in IDLE: nothing starts until annul drops
        div_opdata1 = 32'd100;
        div_opdata2 = 32'd7;
        div_signed  = 1'b0;
        div_start   = 1'b1;
        div_annul   = 1'b1;
        ready_seen  = 0;
        repeat (40) begin
            tick();
            if (div_ready) ready_seen++;
        end
        check("start+annul idle", 65'(ready_seen), 65'd0);
        div_annul = 1'b0;
        tick();
        wait_ready(lat);
        check("start after annul latency", 65'(lat), 65'd33);
        check("start after annul result", {div_ready, div_result}, {1'b1, 32'd2, 32'd14});
        div_start = 1'b0;
        tick();

        // Start dropped during ON: completes silently, END exits without ready
        div_opdata1 = 32'd77;
        div_opdata2 = 32'd5;
        div_start   = 1'b1;
        tick();
        div_start  = 1'b0;
        ready_seen = 0;
        repeat (40) begin
            tick();
            if (div_ready) ready_seen++;
        end
        check("start dropped in ON", 65'(ready_seen), 65'd0);
        run_op("after dropped start", 32'd77, 32'd5, 1'b0, {32'd2, 32'd15}, 33);

        // Random operands against the reference model
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (i % 10 == 5) ra = 32'($urandom_range(0, 20));
            run_op($sformatf("rand%0d", i), ra, rb, rs, ref_div(ra, rb, rs), ref_lat(ra, rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
